// File: rtl/drbg_keystream_feeder.sv
// Seeds a CTR-style DRBG from an entropy source, requests 256-bit blocks one at a
// time and serves them from a two-block buffer as a 32-bit keystream, MSB word first.
module drbg_keystream_feeder #(
    parameter int SEEDLEN      = 256,
    parameter int RESET_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               ent_valid,
    input  logic [SEEDLEN-1:0] ent_data,
    output logic               ent_ready,
    output logic               drbg_reset_n,
    output logic [SEEDLEN-1:0] drbg_entropy,
    output logic               drbg_next,
    input  logic               drbg_init_ready,
    input  logic               drbg_busy,
    input  logic               drbg_next_ready,
    input  logic               drbg_do_reseed,
    input  logic [255:0]       drbg_random_bits,
    output logic               ks_valid,
    output logic [31:0]        ks_data,
    input  logic               ks_ready,
    output logic [15:0]        reseed_count
);

    localparam logic [3:0] RST_LOAD = 4'(RESET_CYCLES - 1);

    typedef enum logic [2:0] {
        SEED_REQ,
        DRBG_RST,
        INIT_WAIT,
        IDLE,
        REQ,
        GEN_WAIT
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [3:0]         r_rst_cnt;
    logic               r_started;
    logic [SEEDLEN-1:0] r_entropy;
    logic [15:0]        r_reseed_cnt;

    logic [255:0]       r_slot [2];
    logic               r_head;
    logic [1:0]         r_count;
    logic [2:0]         r_word_idx;

    logic               w_ent_ready;
    logic               w_drbg_rst_n;
    logic               w_drbg_next;
    logic               w_capture;
    logic               w_reseed;
    logic               w_ent_hs;
    logic               w_has_free;
    logic               w_rd;
    logic               w_pop;
    logic               w_wr_ptr;
    logic [255:0]       w_head_blk;
    logic [31:0]        w_word;

    // Once instantiated, a dropped init_ready means the DRBG lost its state: reseed.
    assign w_reseed   = drbg_do_reseed || !drbg_init_ready;
    assign w_ent_hs   = ent_valid && w_ent_ready;
    assign w_has_free = (r_count != 2'd2);
    assign w_rd       = ks_valid && ks_ready;
    assign w_pop      = w_rd && (r_word_idx == 3'd7);
    assign w_wr_ptr   = r_head ^ r_count[0];

    always_comb begin
        w_state_nxt  = r_state;
        w_ent_ready  = 1'b0;
        w_drbg_rst_n = 1'b1;
        w_drbg_next  = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            SEED_REQ: begin
                w_ent_ready  = r_started;
                w_drbg_rst_n = 1'b0;
                if (ent_valid && r_started) w_state_nxt = DRBG_RST;
            end
            DRBG_RST: begin
                w_drbg_rst_n = 1'b0;
                if (r_rst_cnt == 4'd0) w_state_nxt = INIT_WAIT;
            end
            INIT_WAIT: begin
                if (drbg_init_ready && !drbg_busy) w_state_nxt = IDLE;
            end
            IDLE: begin
                if (w_reseed)                      w_state_nxt = SEED_REQ;
                else if (w_has_free && !drbg_busy) w_state_nxt = REQ;
            end
            REQ: begin
                if (w_reseed) begin
                    w_state_nxt = SEED_REQ;
                end else begin
                    w_drbg_next = 1'b1;
                    if (drbg_busy) w_state_nxt = GEN_WAIT;
                end
            end
            GEN_WAIT: begin
                if (w_reseed) begin
                    w_state_nxt = SEED_REQ;
                end else if (!drbg_busy && drbg_next_ready) begin
                    w_capture   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = SEED_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= SEED_REQ;
            r_started    <= 1'b0;
            r_rst_cnt    <= 4'd0;
            r_entropy    <= '0;
            r_reseed_cnt <= 16'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_started <= 1'b1;
            if (w_ent_hs) begin
                r_rst_cnt <= RST_LOAD;
                r_entropy <= ent_data;
                if (r_reseed_cnt != 16'hFFFF) r_reseed_cnt <= r_reseed_cnt + 16'd1;
            end else if (r_state == DRBG_RST && r_rst_cnt != 4'd0) begin
                r_rst_cnt <= r_rst_cnt - 4'd1;
            end
        end
    end

    // Block storage carries no reset; emptiness is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (w_capture) r_slot[w_wr_ptr] <= drbg_random_bits;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_head     <= 1'b0;
            r_count    <= 2'd0;
            r_word_idx <= 3'd0;
        end else begin
            if (w_rd) r_word_idx <= r_word_idx + 3'd1;
            if (w_pop) r_head <= ~r_head;
            case ({w_capture, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Word 0 is bits [255:224]; inverting the index walks from the top down.
    assign w_head_blk = r_slot[r_head];
    assign w_word     = w_head_blk[{~r_word_idx, 5'b00000} +: 32];

    assign ks_valid     = (r_count != 2'd0);
    assign ks_data      = ks_valid ? w_word : 32'd0;
    assign ent_ready    = w_ent_ready;
    assign drbg_reset_n = w_drbg_rst_n;
    assign drbg_next    = w_drbg_next;
    assign drbg_entropy = r_entropy;
    assign reseed_count = r_reseed_cnt;

endmodule

// File: tb/tb_drbg_keystream_feeder.sv
// Bench for drbg_keystream_feeder: behavioural DRBG plus a word-level scoreboard,
// table-driven start-up sequence and directed reseed/reset corner cases.
module tb_drbg_keystream_feeder;

    logic         clk;
    logic         reset_n;
    logic         ent_valid;
    logic [255:0] ent_data;
    logic         ent_ready;
    logic         drbg_reset_n;
    logic [255:0] drbg_entropy;
    logic         drbg_next;
    logic         drbg_init_ready;
    logic         drbg_busy;
    logic         drbg_next_ready;
    logic         drbg_do_reseed;
    logic [255:0] drbg_random_bits;
    logic         ks_valid;
    logic [31:0]  ks_data;
    logic         ks_ready;
    logic [15:0]  reseed_count;

    drbg_keystream_feeder #(.SEEDLEN(256), .RESET_CYCLES(2)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .ent_valid        (ent_valid),
        .ent_data         (ent_data),
        .ent_ready        (ent_ready),
        .drbg_reset_n     (drbg_reset_n),
        .drbg_entropy     (drbg_entropy),
        .drbg_next        (drbg_next),
        .drbg_init_ready  (drbg_init_ready),
        .drbg_busy        (drbg_busy),
        .drbg_next_ready  (drbg_next_ready),
        .drbg_do_reseed   (drbg_do_reseed),
        .drbg_random_bits (drbg_random_bits),
        .ks_valid         (ks_valid),
        .ks_data          (ks_data),
        .ks_ready         (ks_ready),
        .reseed_count     (reseed_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rdy;
        logic        exp_valid;
        logic [31:0] exp_data;
    } vec_t;

    int          n_checks;
    int          n_errs;
    int          n_words;
    int          m_gen_left;
    int          m_init_left;
    int          m_acc;
    int          m_blk;
    bit          m_drop;
    bit          m_lat_rand;
    bit          ks_mode;
    logic        ks_hold;
    logic [31:0] exp_q [$];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock: choose ks_ready, score any word that will transfer, advance the DRBG.
    task automatic step();
        logic [255:0] b;
        logic [31:0]  wd;
        @(negedge clk);
        if (ks_mode) ks_ready = ($urandom_range(0, 99) < 30) ? 1'b1 : 1'b0;
        else         ks_ready = ks_hold;
        if (ks_valid && ks_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errs++;
                $display("FAIL ks_word: got %0h expected no word", ks_data);
            end else begin
                wd = exp_q.pop_front();
                chk("ks_word", 256'(ks_data), 256'(wd));
                n_words++;
            end
        end
        if (!drbg_reset_n) begin
            drbg_init_ready = 1'b0;
            drbg_busy       = 1'b1;
            drbg_next_ready = 1'b0;
            m_gen_left      = 0;
            m_init_left     = 2;
            m_drop          = 1'b0;
        end else if (m_drop) begin
            drbg_init_ready = 1'b0;
            drbg_busy       = 1'b1;
            drbg_next_ready = 1'b0;
            m_gen_left      = 0;
        end else if (!drbg_init_ready) begin
            if (m_init_left > 0) m_init_left--;
            else begin
                drbg_init_ready = 1'b1;
                drbg_busy       = 1'b0;
            end
        end else if (m_gen_left > 0) begin
            m_gen_left--;
            if (m_gen_left == 0) begin
                b = '0;
                for (int j = 0; j < 8; j++) begin
                    wd = (m_blk < 2) ? 32'(m_blk * 8 + j + 1) : $urandom();
                    b[(7 - j) * 32 +: 32] = wd;
                    exp_q.push_back(wd);
                end
                m_blk++;
                drbg_random_bits = b;
                drbg_busy        = 1'b0;
                drbg_next_ready  = 1'b1;
            end
        end else if (drbg_next && !drbg_busy) begin
            drbg_busy       = 1'b1;
            drbg_next_ready = 1'b0;
            m_acc++;
            m_gen_left = m_lat_rand ? int'($urandom_range(1, 6)) : 3;
        end
    endtask

    task automatic do_seed(input logic [255:0] d);
        logic ok;
        ok        = 1'b0;
        ent_valid = 1'b1;
        ent_data  = d;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (ent_ready) ok = 1'b1;
            step();
        end
        ent_valid = 1'b0;
        chk("seed_handshake", 256'(ok), 256'(1));
    endtask

    initial begin
        vec_t         tbl [12];
        logic [11:0]  rdy_pat;
        int           low;
        int           frozen_bad;
        int           start;
        logic         found;
        logic [15:0]  rc0;
        logic [255:0] seed;

        n_checks = 0; n_errs = 0; n_words = 0;
        m_gen_left = 0; m_init_left = 2; m_acc = 0; m_blk = 0;
        m_drop = 1'b0; m_lat_rand = 1'b0; ks_mode = 1'b0; ks_hold = 1'b0;
        reset_n = 1'b0; ent_valid = 1'b0; ent_data = '0; drbg_do_reseed = 1'b0;
        ks_ready = 1'b0; drbg_init_ready = 1'b0; drbg_busy = 1'b1;
        drbg_next_ready = 1'b0; drbg_random_bits = '0;

        // Start-up stream: word shown before each edge under a stall pattern.
        rdy_pat = 12'b1111_0011_1011;
        for (int i = 0; i < 12; i++) begin
            tbl[i].rdy       = rdy_pat[i];
            tbl[i].exp_valid = 1'b1;
        end
        tbl[0].exp_data = 32'd1;  tbl[1].exp_data  = 32'd2;  tbl[2].exp_data  = 32'd3;
        tbl[3].exp_data = 32'd3;  tbl[4].exp_data  = 32'd4;  tbl[5].exp_data  = 32'd5;
        tbl[6].exp_data = 32'd6;  tbl[7].exp_data  = 32'd6;  tbl[8].exp_data  = 32'd6;
        tbl[9].exp_data = 32'd7;  tbl[10].exp_data = 32'd8;  tbl[11].exp_data = 32'd9;

        repeat (3) step();
        chk("rst_ks_valid", 256'(ks_valid), 256'(0));
        chk("rst_ks_data", 256'(ks_data), 256'(0));
        chk("rst_entropy", drbg_entropy, 256'(0));
        chk("rst_reseed_count", 256'(reseed_count), 256'(0));
        chk("rst_ent_ready", 256'(ent_ready), 256'(0));
        chk("rst_drbg_reset_n", 256'(drbg_reset_n), 256'(0));
        chk("rst_drbg_next", 256'(drbg_next), 256'(0));

        reset_n = 1'b1;
        step();
        chk("ent_ready_after_release", 256'(ent_ready), 256'(1));

        // Power-up seed presented at cycle 3.
        step();
        ent_valid = 1'b1;
        ent_data  = {32{8'hA5}};
        step();
        ent_valid = 1'b0;
        low = 0;
        for (int i = 0; i < 20; i++) begin
            if (drbg_reset_n) break;
            low++;
            step();
        end
        chk("drbg_reset_low_cycles", 256'(low), 256'(2));
        chk("entropy_a5", drbg_entropy, {32{8'hA5}});
        chk("reseed_count_1", 256'(reseed_count), 256'(1));

        // Consumer stalled: buffer fills with exactly two blocks, head word frozen.
        frozen_bad = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (ks_valid && ks_data !== 32'd1) frozen_bad++;
        end
        chk("stall_acceptances", 256'(m_acc), 256'(2));
        chk("stall_frozen", 256'(frozen_bad), 256'(0));
        chk("stall_ks_valid", 256'(ks_valid), 256'(1));
        chk("stall_ks_data", 256'(ks_data), 256'(1));

        for (int i = 0; i < 12; i++) begin
            ks_hold = tbl[i].rdy;
            step();
            chk($sformatf("tbl_valid_%0d", i), 256'(ks_valid), 256'(tbl[i].exp_valid));
            chk($sformatf("tbl_data_%0d", i), 256'(ks_data), 256'(tbl[i].exp_data));
        end
        ks_hold = 1'b0;

        // Reseed request while a block is being generated.
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            step();
            if (drbg_busy && m_gen_left == 3) found = 1'b1;
        end
        chk("gen_started", 256'(found), 256'(1));
        step();
        rc0 = reseed_count;
        drbg_do_reseed = 1'b1;
        step();
        drbg_do_reseed = 1'b0;
        chk("reseed_ent_ready", 256'(ent_ready), 256'(1));
        chk("reseed_drbg_next", 256'(drbg_next), 256'(0));
        chk("reseed_ks_valid", 256'(ks_valid), 256'(1));
        seed = {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
        do_seed(seed);
        chk("reseed_entropy", drbg_entropy, seed);
        chk("reseed_count_inc", 256'(reseed_count), 256'(rc0 + 16'd1));
        ks_hold = 1'b1;
        repeat (40) step();

        // DRBG loses instantiation after init: treated as a reseed request.
        m_drop = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 6 && !found; i++) begin
            step();
            if (ent_ready) found = 1'b1;
        end
        chk("init_drop_reseed", 256'(found), 256'(1));
        do_seed(256'h1234);
        chk("init_drop_entropy", drbg_entropy, 256'h1234);
        repeat (40) step();

        // Reset with one and a half blocks buffered.
        ks_hold = 1'b0;
        repeat (30) step();
        ks_hold = 1'b1;
        repeat (4) step();
        ks_hold = 1'b0;
        step();
        chk("pre_rst_ks_valid", 256'(ks_valid), 256'(1));
        reset_n = 1'b0;
        step();
        chk("pulse_ks_valid", 256'(ks_valid), 256'(0));
        chk("pulse_reseed_count", 256'(reseed_count), 256'(0));
        reset_n = 1'b1;
        exp_q.delete();
        step();
        chk("pulse_seed_req", 256'(ent_ready), 256'(1));
        chk("pulse_drbg_reset_n", 256'(drbg_reset_n), 256'(0));
        do_seed(256'hBEEF);
        chk("pulse_reseed_count_1", 256'(reseed_count), 256'(1));

        // Random consumer backpressure and DRBG latency over 1000 blocks.
        ks_mode    = 1'b1;
        m_lat_rand = 1'b1;
        start      = n_words;
        for (int i = 0; i < 60000 && (n_words - start) < 8000; i++) step();
        chk("random_words_delivered", 256'((n_words - start) >= 8000), 256'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
